// File: rtl/alu_status_if.sv
// Bus between the ALU and control unit on one side and alu_status_unit on the other.
// master = ALU/control side driving op data and acks, slave = the status unit.
interface alu_status_if #(
    parameter int CNT_W = 8
);
    logic             valid_in;
    logic [3:0]       control_in;
    logic [31:0]      result_in;
    logic [7:0]       status_in;
    logic [31:0]      pc_in;
    logic             exc_ack;
    logic             clear_flags;
    logic [7:0]       flags_out;
    logic             exc_req;
    logic [3:0]       exc_cause;
    logic [31:0]      exc_pc;
    logic [31:0]      exc_badaddr;
    logic [CNT_W-1:0] exc_count;
    logic             stall_out;

    modport master (
        output valid_in, control_in, result_in, status_in, pc_in, exc_ack, clear_flags,
        input  flags_out, exc_req, exc_cause, exc_pc, exc_badaddr, exc_count, stall_out
    );

    modport slave (
        input  valid_in, control_in, result_in, status_in, pc_in, exc_ack, clear_flags,
        output flags_out, exc_req, exc_cause, exc_pc, exc_badaddr, exc_count, stall_out
    );
endinterface

// File: rtl/alu_status_unit.sv
// Registers ALU status flags and raises a held exception request (with stall) until acked.
// Define ALU_STATUS_STICKY_EN to make flags [6:5] and [3:2] accumulate until clear_flags.
module alu_status_unit #(
    parameter logic [2:0] EXC_MASK = 3'b000,
    parameter int         CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    alu_status_if.slave  bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic             accept_p0;
    logic             div0_p0;
    logic             mulovf_p0;
    logic             misalign_p0;
    logic             raise_p0;
    logic [3:0]       cause_p0;
    logic [7:0]       flags_nxt_p0;
    logic             ack_p0;

    logic [7:0]       flags_p1;
    logic [3:0]       cause_p1;
    logic [31:0]      pc_p1;
    logic [31:0]      badaddr_p1;
    logic [CNT_W-1:0] count_p1;

    logic             unused_status;
    assign unused_status = &{1'b0, bus.status_in[1:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Stage p0: decode the incoming op against the current FSM state
    always_comb begin
        accept_p0   = bus.valid_in && (state == IDLE);
        ack_p0      = bus.exc_ack && (state == PENDING);
        div0_p0     = bus.status_in[2] && (bus.control_in == 4'd4);
        mulovf_p0   = bus.status_in[6] && (bus.control_in == 4'd5);
        misalign_p0 = bus.status_in[3] &&
                      ((bus.control_in == 4'd12) || (bus.control_in == 4'd13));

        // Causes are exclusive by control code, so masking before prioritising is safe
        cause_p0 = 4'd0;
        if (div0_p0 && !EXC_MASK[0])
            cause_p0 = 4'd1;
        else if (mulovf_p0 && !EXC_MASK[1])
            cause_p0 = 4'd2;
        else if (misalign_p0 && !EXC_MASK[2])
            cause_p0 = 4'd3;
        raise_p0 = accept_p0 && (cause_p0 != 4'd0);

`ifdef ALU_STATUS_STICKY_EN
        flags_nxt_p0 = {bus.status_in[7], flags_p1[6:5] | bus.status_in[6:5],
                        bus.status_in[4], flags_p1[3:2] | bus.status_in[3:2], 2'b00};
`else
        flags_nxt_p0 = {bus.status_in[7:2], 2'b00};
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (raise_p0) state_nxt = PENDING;
            PENDING: if (bus.exc_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Stage p1: registered flags, exception record and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_p1   <= 8'h00;
            cause_p1   <= 4'd0;
            pc_p1      <= 32'h0;
            badaddr_p1 <= 32'h0;
            count_p1   <= '0;
        end else begin
            if (ack_p0) begin
                cause_p1   <= 4'd0;
                pc_p1      <= 32'h0;
                badaddr_p1 <= 32'h0;
            end else if (raise_p0) begin
                cause_p1   <= cause_p0;
                pc_p1      <= bus.pc_in;
                badaddr_p1 <= (cause_p0 == 4'd3) ? bus.result_in : 32'h0;
            end

            if (bus.clear_flags) begin
                flags_p1 <= 8'h00;
                count_p1 <= '0;
            end else begin
                if (accept_p0)
                    flags_p1 <= flags_nxt_p0;
                if (raise_p0)
                    count_p1 <= sat_inc(count_p1);
            end
        end
    end

    assign bus.flags_out   = flags_p1;
    assign bus.exc_req     = (state == PENDING);
    assign bus.stall_out   = (state == PENDING);
    assign bus.exc_cause   = cause_p1;
    assign bus.exc_pc      = pc_p1;
    assign bus.exc_badaddr = badaddr_p1;
    assign bus.exc_count   = count_p1;
endmodule
